// File: rtl/usb_host_token_tx_if.sv
// UTMI+ transmit-side bundle between the host token engine (master) and the host MAC (slave).
interface usb_host_token_tx_if;
  logic [7:0] utmi_tx_data;
  logic       utmi_tx_valid;
  logic       utmi_tx_first;
  logic       utmi_tx_last;
  logic       utmi_tx_ready;
  logic       utmi_host_disconnect;

  modport master (
    output utmi_tx_data, utmi_tx_valid, utmi_tx_first, utmi_tx_last,
    input  utmi_tx_ready, utmi_host_disconnect
  );

  modport slave (
    input  utmi_tx_data, utmi_tx_valid, utmi_tx_first, utmi_tx_last,
    output utmi_tx_ready, utmi_host_disconnect
  );
endinterface

// File: rtl/usb_host_token_tx.sv
// Host-side UTMI+ transmit engine: emits SETUP/IN/OUT tokens with CRC5 and, for SETUP,
// a following DATA0 packet carrying the 8-byte request plus CRC16.
module usb_host_token_tx #(
  parameter int unsigned IPG_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [3:0]                 pid,
  input  logic [6:0]                 dev_addr,
  input  logic [3:0]                 endp,
  input  logic [63:0]                setup_data,
  usb_host_token_tx_if.master        utmi,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_TOK_PID,
    S_TOK_B1,
    S_TOK_B2,
    S_GAP,
    S_DAT_PID,
    S_DAT_BYTE,
    S_CRC_LO,
    S_CRC_HI,
    S_DONE
  } state_e;

  localparam logic [3:0] PID_SETUP  = 4'hD;
  localparam logic [3:0] PID_IN     = 4'h9;
  localparam logic [3:0] PID_OUT    = 4'h1;
  localparam logic [7:0] DATA0_BYTE = 8'hC3;
  localparam logic [7:0] GAP_LOAD   = 8'(IPG_CYCLES - 1);

  // Reflected CRC5 over {endp, addr} LSB-first; bit 0 of the result goes on the wire first.
  function automatic logic [4:0] crc5_token(input logic [6:0] addr, input logic [3:0] ep);
    logic [10:0] bits;
    logic [4:0]  r;
    bits = {ep, addr};
    r    = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      r = (r[0] ^ bits[i]) ? ((r >> 1) ^ 5'h14) : (r >> 1);
    end
    return ~r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  pid_q, pid_d;
  logic [6:0]  addr_q, addr_d;
  logic [3:0]  endp_q, endp_d;
  logic [63:0] data_q, data_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] crc16_q, crc16_d;
  logic        aborted_q, aborted_d;

  logic [4:0]  crc5;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_first;
  logic        tx_last;
  logic        pid_ok;

  assign crc5   = crc5_token(addr_q, endp_q);
  assign pid_ok = (pid == PID_SETUP) || (pid == PID_IN) || (pid == PID_OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pid_q      <= '0;
      addr_q     <= '0;
      endp_q     <= '0;
      data_q     <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      crc16_q    <= 16'hFFFF;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pid_q      <= pid_d;
      addr_q     <= addr_d;
      endp_q     <= endp_d;
      data_q     <= data_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      crc16_q    <= crc16_d;
      aborted_q  <= aborted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pid_d      = pid_q;
    addr_d     = addr_q;
    endp_d     = endp_q;
    data_d     = data_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    crc16_d    = crc16_q;
    aborted_d  = 1'b0;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    tx_first   = 1'b0;
    tx_last    = 1'b0;
    done       = 1'b0;
    busy       = (state_q != S_IDLE) && (state_q != S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (pid_ok) begin
            pid_d   = pid;
            addr_d  = dev_addr;
            endp_d  = endp;
            data_d  = setup_data;
            state_d = S_TOK_PID;
          end else begin
            aborted_d = 1'b1;
          end
        end
      end
      S_TOK_PID: begin
        tx_valid = 1'b1;
        tx_first = 1'b1;
        tx_data  = {~pid_q, pid_q};
        if (utmi.utmi_tx_ready) state_d = S_TOK_B1;
      end
      S_TOK_B1: begin
        tx_valid = 1'b1;
        tx_data  = {endp_q[0], addr_q};
        if (utmi.utmi_tx_ready) state_d = S_TOK_B2;
      end
      S_TOK_B2: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = {crc5, endp_q[3:1]};
        if (utmi.utmi_tx_ready) begin
          if (pid_q == PID_SETUP) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 8'd0) state_d = S_DAT_PID;
        else                   gap_cnt_d = gap_cnt_q - 8'd1;
      end
      S_DAT_PID: begin
        tx_valid = 1'b1;
        tx_first = 1'b1;
        tx_data  = DATA0_BYTE;
        if (utmi.utmi_tx_ready) begin
          state_d    = S_DAT_BYTE;
          byte_cnt_d = 3'd0;
          crc16_d    = 16'hFFFF;
        end
      end
      S_DAT_BYTE: begin
        tx_valid = 1'b1;
        tx_data  = data_q[7:0];
        // CRC folds in each byte as it is accepted, so the CRC is ready right after byte 7.
        if (utmi.utmi_tx_ready) begin
          crc16_d    = crc16_byte(crc16_q, data_q[7:0]);
          data_d     = data_q >> 8;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd7) state_d = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        tx_valid = 1'b1;
        tx_data  = ~crc16_q[7:0];
        if (utmi.utmi_tx_ready) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = ~crc16_q[15:8];
        if (utmi.utmi_tx_ready) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A detach overrides any handshake progress made in the same cycle.
    if (busy && utmi.utmi_host_disconnect) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end
  end

  assign utmi.utmi_tx_data  = tx_data;
  assign utmi.utmi_tx_valid = tx_valid;
  assign utmi.utmi_tx_first = tx_first;
  assign utmi.utmi_tx_last  = tx_last;
  assign aborted            = aborted_q;

endmodule

// File: tb/tb_usb_host_token_tx.sv
// Directed self-checking bench for usb_host_token_tx: SETUP/IN streams, backpressure,
// ignored restarts, invalid PID, disconnect and reset-in-gap recovery.
module tb_usb_host_token_tx;

  localparam int IPG = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  pid;
  logic [6:0]  devAddr;
  logic [3:0]  endp;
  logic [63:0] setupData;
  logic        busy;
  logic        done;
  logic        aborted;

  usb_host_token_tx_if utmiIf();

  usb_host_token_tx #(.IPG_CYCLES(IPG)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pid        (pid),
    .dev_addr   (devAddr),
    .endp       (endp),
    .setup_data (setupData),
    .utmi       (utmiIf),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transfer log filled by the negedge monitor.
  logic [7:0] qData[$];
  bit         qFirst[$];
  bit         qLast[$];
  int         qCyc[$];

  int cyc = 0;
  int doneCount, doneCyc, abortCount, abortCyc, bothHigh, validCycles, busyCycles;
  int startCyc;
  bit doneBusy;

  bit         pValid = 1'b0;
  bit         pReady = 1'b0;
  bit         pFirst, pLast;
  logic [7:0] pData;

  bit bpEnable = 1'b0;
  bit xferSeen = 1'b0;
  int stallLeft = 0;

  logic [7:0] expSetup [14] = '{8'h2D, 8'h00, 8'h10, 8'hC3, 8'h80, 8'h06, 8'h00,
                                8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
  logic [7:0] expIn [3] = '{8'h69, 8'h15, 8'hEF};

  localparam logic [63:0] SETUP_REQ = 64'h0040_0000_0100_0680;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Monitor: logs accepted bytes, pulses, and checks that stalled bytes are held stable.
  always @(negedge clk) begin
    cyc++;
    if (utmiIf.utmi_tx_valid === 1'b1) validCycles++;
    if (busy === 1'b1) busyCycles++;
    if (pValid && !pReady)
      checkOutput("stall_hold",
                  {53'd0, utmiIf.utmi_tx_valid, utmiIf.utmi_tx_first, utmiIf.utmi_tx_last, utmiIf.utmi_tx_data},
                  {53'd0, 1'b1, pFirst, pLast, pData});
    if (utmiIf.utmi_tx_valid === 1'b1 && utmiIf.utmi_tx_ready === 1'b1) begin
      qData.push_back(utmiIf.utmi_tx_data);
      qFirst.push_back(utmiIf.utmi_tx_first);
      qLast.push_back(utmiIf.utmi_tx_last);
      qCyc.push_back(cyc);
      xferSeen = 1'b1;
    end
    if (done === 1'b1) begin
      doneCount++;
      doneCyc  = cyc;
      doneBusy = busy;
    end
    if (aborted === 1'b1) begin
      abortCount++;
      abortCyc = cyc;
    end
    if (done === 1'b1 && aborted === 1'b1) bothHigh++;
    pValid = (utmiIf.utmi_tx_valid === 1'b1);
    pReady = (utmiIf.utmi_tx_ready === 1'b1);
    pFirst = utmiIf.utmi_tx_first;
    pLast  = utmiIf.utmi_tx_last;
    pData  = utmiIf.utmi_tx_data;
  end

  // Ready driver: always 1, or 0-3 stall cycles before each byte when backpressure is on.
  always @(posedge clk) begin
    #1;
    if (!bpEnable) begin
      utmiIf.utmi_tx_ready = 1'b1;
    end else begin
      if (xferSeen) begin
        stallLeft = $urandom_range(0, 3);
        xferSeen  = 1'b0;
      end
      if (stallLeft > 0) begin
        utmiIf.utmi_tx_ready = 1'b0;
        stallLeft--;
      end else begin
        utmiIf.utmi_tx_ready = 1'b1;
      end
    end
  end

  task automatic clearLog();
    qData.delete();
    qFirst.delete();
    qLast.delete();
    qCyc.delete();
    doneCount   = 0;
    abortCount  = 0;
    validCycles = 0;
    busyCycles  = 0;
    doneCyc     = -1;
    abortCyc    = -1;
  endtask

  task automatic applyStimulus(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                               input logic [63:0] d);
    @(posedge clk);
    #1;
    pid       = p;
    devAddr   = a;
    endp      = e;
    setupData = d;
    start     = 1'b1;
    startCyc  = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int maxCycles);
    int n;
    n = 0;
    while (doneCount == 0 && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    checkOutput({tag, "_finished"}, 64'(doneCount > 0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic waitBytes(input string tag, input int count, input int maxCycles);
    int n;
    n = 0;
    while (qData.size() < count && n < maxCycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_reached"}, 64'(qData.size()), 64'(count));
  endtask

  task automatic checkSetupStream(input string tag, input bit checkTiming);
    checkOutput({tag, "_len"}, 64'(qData.size()), 64'd14);
    if (qData.size() == 14) begin
      for (int i = 0; i < 14; i++) begin
        checkOutput($sformatf("%s_byte%0d", tag, i), 64'(qData[i]), 64'(expSetup[i]));
        checkOutput($sformatf("%s_flags%0d", tag, i), {62'd0, qFirst[i], qLast[i]},
                    {62'd0, (i == 0 || i == 3), (i == 2 || i == 13)});
      end
      if (checkTiming) begin
        checkOutput({tag, "_latency"}, 64'(qCyc[0] - startCyc), 64'd2);
        checkOutput({tag, "_gap"}, 64'(qCyc[3] - qCyc[2]), 64'(IPG + 1));
      end
      checkOutput({tag, "_done_delay"}, 64'(doneCyc - qCyc[13]), 64'd1);
    end
    checkOutput({tag, "_done_count"}, 64'(doneCount), 64'd1);
    checkOutput({tag, "_busy_at_done"}, 64'(doneBusy), 64'd0);
    checkOutput({tag, "_abort_count"}, 64'(abortCount), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    pid       = 4'h0;
    devAddr   = 7'h00;
    endp      = 4'h0;
    setupData = 64'd0;
    utmiIf.utmi_host_disconnect = 1'b0;
    clearLog();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs",
                {50'd0, utmiIf.utmi_tx_valid, utmiIf.utmi_tx_first, utmiIf.utmi_tx_last,
                 utmiIf.utmi_tx_data, busy, done, aborted},
                64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] SETUP addr 0 endp 0, ready always high");
    clearLog();
    applyStimulus(4'hD, 7'h00, 4'h0, SETUP_REQ);
    waitDone("setup", 300);
    checkSetupStream("setup", 1'b1);

    $display("[TB] IN addr 15 endp E");
    clearLog();
    applyStimulus(4'h9, 7'h15, 4'hE, 64'hDEAD_BEEF_0123_4567);
    waitDone("in", 300);
    checkOutput("in_len", 64'(qData.size()), 64'd3);
    if (qData.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("in_byte%0d", i), 64'(qData[i]), 64'(expIn[i]));
        checkOutput($sformatf("in_flags%0d", i), {62'd0, qFirst[i], qLast[i]},
                    {62'd0, (i == 0), (i == 2)});
      end
      checkOutput("in_done_delay", 64'(doneCyc - qCyc[2]), 64'd1);
    end
    checkOutput("in_done_count", 64'(doneCount), 64'd1);

    $display("[TB] SETUP with random ready backpressure");
    bpEnable = 1'b1;
    clearLog();
    applyStimulus(4'hD, 7'h00, 4'h0, SETUP_REQ);
    waitDone("bp", 500);
    checkSetupStream("bp", 1'b0);
    bpEnable = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] restart while busy is ignored");
    clearLog();
    applyStimulus(4'hD, 7'h00, 4'h0, SETUP_REQ);
    repeat (4) @(posedge clk);
    #1;
    pid       = 4'h9;
    devAddr   = 7'h55;
    endp      = 4'h3;
    setupData = 64'hFFFF_FFFF_FFFF_FFFF;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("restart", 300);
    checkSetupStream("restart", 1'b1);

    $display("[TB] invalid pid 5 in idle");
    clearLog();
    applyStimulus(4'h5, 7'h01, 4'h1, SETUP_REQ);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("badpid_abort_count", 64'(abortCount), 64'd1);
    checkOutput("badpid_abort_delay", 64'(abortCyc - startCyc), 64'd2);
    checkOutput("badpid_valid_cycles", 64'(validCycles), 64'd0);
    checkOutput("badpid_busy_cycles", 64'(busyCycles), 64'd0);
    checkOutput("badpid_done_count", 64'(doneCount), 64'd0);

    $display("[TB] disconnect during data byte 3");
    clearLog();
    applyStimulus(4'hD, 7'h00, 4'h0, SETUP_REQ);
    waitBytes("disc", 7, 300);
    checkOutput("disc_cur_byte", 64'(utmiIf.utmi_tx_data), 64'h01);
    utmiIf.utmi_host_disconnect = 1'b1;
    @(posedge clk);
    #1;
    utmiIf.utmi_host_disconnect = 1'b0;
    @(negedge clk);
    checkOutput("disc_outputs", {60'd0, utmiIf.utmi_tx_valid, busy, done, aborted}, 64'h1);
    @(negedge clk);
    checkOutput("disc_abort_pulse", 64'(aborted), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("disc_no_done", 64'(doneCount), 64'd0);
    checkOutput("disc_abort_count", 64'(abortCount), 64'd1);
    clearLog();
    applyStimulus(4'hD, 7'h00, 4'h0, SETUP_REQ);
    waitDone("after_disc", 300);
    checkSetupStream("after_disc", 1'b1);

    $display("[TB] reset asserted during inter-packet gap");
    clearLog();
    applyStimulus(4'hD, 7'h00, 4'h0, SETUP_REQ);
    waitBytes("rstgap", 3, 300);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstgap_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstgap_outputs",
                {50'd0, utmiIf.utmi_tx_valid, utmiIf.utmi_tx_first, utmiIf.utmi_tx_last,
                 utmiIf.utmi_tx_data, busy, done, aborted},
                64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("rstgap_no_resume", 64'(qData.size()), 64'd3);
    checkOutput("rstgap_no_done", 64'(doneCount), 64'd0);
    clearLog();
    applyStimulus(4'hD, 7'h00, 4'h0, SETUP_REQ);
    waitDone("after_rst", 300);
    checkSetupStream("after_rst", 1'b1);

    checkOutput("done_abort_overlap", 64'(bothHigh), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_host_token_tx.md
Name: usb_host_token_tx

Overview:
- Host-side UTMI+ transmit engine that serialises the packets the host control logic must emit.
- Emits a token packet (SETUP/IN/OUT) with CRC5.
- For SETUP, follows the token with a DATA0 packet carrying the 8-byte setup request plus CRC16.
- Sits between the host enumeration FSM and the UTMI+ TX interface of the host MAC. It is the transmit counterpart of the descriptor receive/parse path.

Parameters:
- IPG_CYCLES, 8, idle clk cycles between the token's last byte accept and the DATA0 PID assertion (range 1-255).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- pid  input  4  token PID: 4'hD SETUP, 4'h9 IN, 4'h1 OUT; other values rejected
- dev_addr  input  7  target device address
- endp  input  4  target endpoint
- setup_data  input  64  setup request; byte0 (bmRequestType) in [7:0], byte7 in [63:56]
- utmi_tx_ready  input  1  UTMI accepts current byte
- utmi_host_disconnect  input  1  device detached; aborts transfer
- utmi_tx_data  output  8  byte to transmit
- utmi_tx_valid  output  1  byte valid
- utmi_tx_first  output  1  current byte is a packet PID
- utmi_tx_last  output  1  current byte is last of packet
- busy  output  1  high from accepted start until done/abort
- done  output  1  one-cycle pulse: transfer fully sent
- aborted  output  1  one-cycle pulse: transfer abandoned (disconnect) or pid rejected

Behaviour:
- Reset values: all outputs 0; state IDLE. rst has priority over every other condition, including mid-packet; valid drops the cycle after rst is asserted.
- Latch on start: in IDLE, start=1 latches pid, dev_addr, endp and setup_data, and sets busy the next cycle. Later input changes are ignored.
- Start while busy: ignored.
- Invalid pid: aborted pulses 1 cycle later; no bytes sent; busy stays 0.
- Handshake: utmi_tx_data/first/last are held stable while utmi_tx_valid=1 until a cycle with utmi_tx_ready=1. A byte transfers on valid&&ready; the next byte (or valid=0) appears the following cycle. No bubbles within a packet.
- State sequence: IDLE -> TOK_PID -> TOK_B1 -> TOK_B2.
  - Non-SETUP token: -> DONE.
  - SETUP: -> GAP -> DAT_PID -> DAT_BYTE (x8) -> CRC_LO -> CRC_HI -> DONE -> IDLE.
- PID byte is {~pid, pid}: SETUP=8'h2D, IN=8'h69, OUT=8'hE1, DATA0=8'hC3. utmi_tx_first=1 only on PID bytes.
- Token:
  - TOK_B1 = {endp[0], dev_addr[6:0]}.
  - TOK_B2 = {crc5[4:0], endp[3:1]}.
  - crc5: poly x^5+x^2+1, init 5'b11111, over the 11 bits {endp, addr} LSB-first, final result inverted, bit order per USB 2.0 section 8.3.5.
  - utmi_tx_last=1 on TOK_B2.
- GAP:
  - valid=0 for exactly IPG_CYCLES cycles, counted from the cycle after TOK_B2 is accepted.
  - DAT_PID is asserted on the following cycle.
- Data:
  - 8 setup bytes, byte0 first.
  - crc16: poly x^16+x^15+x^2+1, init 16'hFFFF, LSB-first over the 8 data bytes, inverted. Sent as low byte then high byte.
  - utmi_tx_last=1 on CRC_HI.
  - CRC is computed incrementally as each byte is accepted.
- done: pulses 1 cycle after the final byte is accepted; busy falls the same cycle.
- Disconnect: utmi_host_disconnect=1 in any busy state drops valid next cycle, pulses aborted, clears busy, returns to IDLE. No done pulse.
- done and aborted are never high together.

Test Plan:
- SETUP, addr 0, endp 0, setup_data bytes 80 06 00 01 00 00 40 00, tx_ready always 1.
  - Bytes: 2D 00 10, then IPG_CYCLES valid-low cycles, then C3 80 06 00 01 00 00 40 00 DD 94.
  - first on 2D and C3; last on 10 and 94; done 1 cycle after 94.
- IN, addr 7'h15, endp 4'hE: bytes 69 15 then {crc5, 3'b111} matching reference CRC5 model; no data packet; done pulses.
- Random tx_ready backpressure (0 for 0-3 cycles per byte) on the SETUP case: identical byte stream; data/first/last stable during every stall.
- start asserted again mid-transfer and pid=4'h5: second start ignored. pid 4'h5 in IDLE gives aborted pulse, no valid.
- utmi_host_disconnect during DAT_BYTE 3: valid low next cycle, aborted=1, busy=0. New start afterwards transmits correctly from 2D.
- rst asserted during GAP: all outputs 0 next cycle. Transfer after reset is bit-identical to the first scenario.
